// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared types and default constants for transpose_bank
//
// Purpose: state and direction enums for the auto-repeat FSM, default
// parameter values for transpose_bank, and the button-to-direction decode.
// Ports: none (package).

package transpose_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_e;

    localparam int DEF_W       = 5;
    localparam int DEF_NCH     = 4;
    localparam int DEF_MIN_V   = 0;
    localparam int DEF_MAX_V   = 19;
    localparam int DEF_DEF_V   = 7;
    localparam int DEF_WRAP    = 0;
    localparam int DEF_RPT_DLY = 50000000;
    localparam int DEF_RPT_PER = 10000000;

    // Both buttons pressed together means "no request".
    function automatic dir_e decode_dir(input logic up, input logic dn);
        if (up && !dn) begin
            return UP;
        end else if (dn && !up) begin
            return DN;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/transpose_bank_btn_repeat.sv
// rtl/transpose_bank_btn_repeat.sv - press/hold auto-repeat step generator
//
// Purpose: turns a held direction into one immediate step, then a step after
// RPT_DLY cycles, then one step every RPT_PER cycles while the same direction
// stays held. Any change of direction drops back to IDLE without a step.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   i_dir      requested direction (dir_e encoding)
//   o_step_up  combinational one-cycle increment request
//   o_step_dn  combinational one-cycle decrement request

import transpose_pkg::*;

module btn_repeat #(
    parameter int RPT_DLY = DEF_RPT_DLY,
    parameter int RPT_PER = DEF_RPT_PER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_dir,
    output logic       o_step_up,
    output logic       o_step_dn
);

    localparam logic [31:0] DLY_LAST = 32'(RPT_DLY - 1);
    localparam logic [31:0] PER_LAST = 32'(RPT_PER - 1);

    rpt_state_e  r_state;
    dir_e        r_ldir;
    logic [31:0] r_cnt;

    dir_e        w_dir;
    dir_e        w_step;
    rpt_state_e  w_state_nxt;
    dir_e        w_ldir_nxt;
    logic [31:0] w_cnt_nxt;

    assign w_dir = dir_e'(i_dir);

    always_comb begin
        w_step      = NONE;
        w_state_nxt = r_state;
        w_ldir_nxt  = r_ldir;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_dir != NONE) begin
                    w_step      = w_dir;
                    w_ldir_nxt  = w_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DELAY;
                end
            end
            DELAY: begin
                // Release, both-pressed and reversal all look like dir != ldir.
                if (w_dir != r_ldir) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DLY_LAST) begin
                    w_step      = r_ldir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            REPEAT: begin
                if (w_dir != r_ldir) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == PER_LAST) begin
                    w_step    = r_ldir;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ldir  <= NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ldir  <= w_ldir_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_step_up = (w_step == UP);
    assign o_step_dn = (w_step == DN);

endmodule

// File: rtl/transpose_bank.sv
// rtl/transpose_bank.sv - multi-channel bounded shift-value register bank
//
// Purpose: NCH independent W-bit values kept in [MIN_V, MAX_V], stepped up or
// down by two level buttons with press-and-hold auto-repeat, on the channel
// addressed by ch_sel. Boundary behaviour is saturate (WRAP=0) or wrap (WRAP=1).
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   btn_dn     decrement request level
//   btn_up     increment request level
//   ch_sel     target channel; out-of-range values are ignored
//   ch_rst     restore selected channel to DEF_V (wins over a step)
//   shift_all  every channel, channel i at [i*W +: W]
//   shift_sel  selected channel value (0 when ch_sel is out of range)
//   changed    pulse: a stored value changed on the previous edge
//   at_min     selected channel equals MIN_V
//   at_max     selected channel equals MAX_V

import transpose_pkg::*;

module transpose_bank #(
    parameter int W       = DEF_W,
    parameter int NCH     = DEF_NCH,
    parameter int MIN_V   = DEF_MIN_V,
    parameter int MAX_V   = DEF_MAX_V,
    parameter int DEF_V   = DEF_DEF_V,
    parameter int WRAP    = DEF_WRAP,
    parameter int RPT_DLY = DEF_RPT_DLY,
    parameter int RPT_PER = DEF_RPT_PER,
    localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_dn,
    input  logic             btn_up,
    input  logic [SELW-1:0]  ch_sel,
    input  logic             ch_rst,
    output logic [NCH*W-1:0] shift_all,
    output logic [W-1:0]     shift_sel,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);

    if (!(NCH >= 1 && W >= 1 && W < 31 && MIN_V >= 0 && MIN_V <= DEF_V &&
          DEF_V <= MAX_V && MAX_V < (1 << W) && RPT_DLY >= 1 && RPT_PER >= 1))
    begin : g_bad_params
        $error("transpose_bank: illegal parameter combination");
    end

    localparam logic [W-1:0] L_MIN = W'(MIN_V);
    localparam logic [W-1:0] L_MAX = W'(MAX_V);
    localparam logic [W-1:0] L_DEF = W'(DEF_V);

    logic [W-1:0] r_val [NCH];
    logic         r_changed;

    logic [1:0]   w_dir;
    logic         w_up;
    logic         w_dn;
    logic         w_sel_ok;
    logic [W-1:0] w_cur;
    logic [W-1:0] w_nxt;

    assign w_dir = decode_dir(btn_up, btn_dn);

    btn_repeat #(
        .RPT_DLY (RPT_DLY),
        .RPT_PER (RPT_PER)
    ) u_btn_repeat (
        .clk       (clk),
        .rst       (rst),
        .i_dir     (w_dir),
        .o_step_up (w_up),
        .o_step_dn (w_dn)
    );

    assign w_sel_ok = (32'(ch_sel) < 32'(NCH));

    // Mux by loop so that non-power-of-two NCH never indexes past the array.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == ch_sel) begin
                w_cur = r_val[i];
            end
        end
    end

    always_comb begin
        w_nxt = w_cur;
        if (ch_rst) begin
            w_nxt = L_DEF;
        end else if (w_up) begin
            if (w_cur == L_MAX) begin
                w_nxt = (WRAP != 0) ? L_MIN : w_cur;
            end else begin
                w_nxt = w_cur + W'(1);
            end
        end else if (w_dn) begin
            if (w_cur == L_MIN) begin
                w_nxt = (WRAP != 0) ? L_MAX : w_cur;
            end else begin
                w_nxt = w_cur - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_val[i] <= L_DEF;
            end
            r_changed <= 1'b0;
        end else begin
            // Pulse only on a real value change, so a saturated step or a
            // ch_rst on a channel already at DEF_V stays silent.
            r_changed <= w_sel_ok && (w_nxt != w_cur);
            for (int i = 0; i < NCH; i++) begin
                if (w_sel_ok && (SELW'(i) == ch_sel)) begin
                    r_val[i] <= w_nxt;
                end
            end
        end
    end

    always_comb begin
        shift_all = '0;
        for (int i = 0; i < NCH; i++) begin
            shift_all[i*W +: W] = r_val[i];
        end
    end

    assign shift_sel = w_sel_ok ? w_cur : '0;
    assign at_min    = w_sel_ok && (w_cur == L_MIN);
    assign at_max    = w_sel_ok && (w_cur == L_MAX);
    assign changed   = r_changed;

endmodule
